// File: rtl/alu_issue_if.sv
// Command and result handshake bundle for alu_issue.
// Ports: command valid/ready + {A,B,INST}; result valid/ready + {RESULT,DIVZ}.
interface alu_issue_if;
   // command side
   logic       iCMD_VALID;
   logic       oCMD_READY;
   logic [3:0] iCMD_A;
   logic [3:0] iCMD_B;
   logic [3:0] iCMD_INST;
   // result side
   logic       oRES_VALID;
   logic       iRES_READY;
   logic [7:0] oRESULT;
   logic       oDIVZ;

   // slave: the issue stage itself
   modport slave (
      input  iCMD_VALID,
      input  iCMD_A,
      input  iCMD_B,
      input  iCMD_INST,
      input  iRES_READY,
      output oCMD_READY,
      output oRES_VALID,
      output oRESULT,
      output oDIVZ
   );

   // master: command producer / result consumer
   modport master (
      output iCMD_VALID,
      output iCMD_A,
      output iCMD_B,
      output iCMD_INST,
      output iRES_READY,
      input  oCMD_READY,
      input  oRES_VALID,
      input  oRESULT,
      input  oDIVZ
   );
endinterface

// File: rtl/alu_issue.sv
// Issue stage around a combinational 4-bit ALU: command FIFO, registered
// operand lines, one-cycle execute, registered result with DIV/MOD-by-zero flag.
// Ports: iCLK, iRSTn (async, active-low); bus (alu_issue_if.slave) carries the
// command and result handshakes; oA/oB/oINST drive the ALU, iALU_RESULT
// returns its 8-bit result; oCOUNT is FIFO occupancy.
module alu_issue #(
   parameter int DEPTH = 4
) (
   input  logic                     iCLK,
   input  logic                     iRSTn,
   alu_issue_if.slave               bus,
   output logic [3:0]               oA,
   output logic [3:0]               oB,
   output logic [3:0]               oINST,
   input  logic [7:0]               iALU_RESULT,
   output logic [$clog2(DEPTH):0]   oCOUNT
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   localparam logic [3:0] OP_DIV = 4'h3;
   localparam logic [3:0] OP_MOD = 4'h4;

   typedef struct packed {
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] inst;
   } cmd_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      OUT  = 2'd2
   } state_t;

   // ---------------------------------------------------------------
   // state
   // ---------------------------------------------------------------
   state_t          state_q, state_d;

   cmd_t            mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [3:0]      a_q, b_q, inst_q;
   logic [7:0]      res_q, res_d;
   logic            divz_q, divz_d;

   logic            push;
   logic            pop;
   logic            cap;
   logic            not_empty;
   logic            div_by_zero;
   cmd_t            head;
   cmd_t            wr_ent;

   // ---------------------------------------------------------------
   // FIFO control
   // ---------------------------------------------------------------
   // Readiness uses only the registered count: a full FIFO stays
   // closed even when the head is leaving this cycle.
   assign bus.oCMD_READY = (cnt_q != FULL);
   assign push           = bus.iCMD_VALID & bus.oCMD_READY;
   assign not_empty      = (cnt_q != '0);
   assign head           = mem_q[rd_ptr_q];

   assign wr_ent.a    = bus.iCMD_A;
   assign wr_ent.b    = bus.iCMD_B;
   assign wr_ent.inst = bus.iCMD_INST;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge iCLK) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr_ent;
      end
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // ---------------------------------------------------------------
   // sequencing FSM
   // ---------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      cap     = 1'b0;
      case (state_q)
         IDLE: begin
            if (not_empty) begin
               pop     = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            cap     = 1'b1;
            state_d = OUT;
         end
         OUT: begin
            if (bus.iRES_READY) begin
               if (not_empty) begin
                  pop     = 1'b1;
                  state_d = EXEC;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------
   // operand lines: loaded on pop, held otherwise
   // ---------------------------------------------------------------
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         a_q    <= '0;
         b_q    <= '0;
         inst_q <= '0;
      end else if (pop) begin
         a_q    <= head.a;
         b_q    <= head.b;
         inst_q <= head.inst;
      end
   end

   assign oA     = a_q;
   assign oB     = b_q;
   assign oINST  = inst_q;
   assign oCOUNT = cnt_q;

   // ---------------------------------------------------------------
   // result capture
   // ---------------------------------------------------------------
   // Whatever the ALU drives for a zero divisor is replaced by 0.
   assign div_by_zero = ((inst_q == OP_DIV) || (inst_q == OP_MOD))
                        && (b_q == 4'h0);

   always_comb begin
      res_d  = res_q;
      divz_d = divz_q;
      if (cap) begin
         if (div_by_zero) begin
            res_d  = 8'h00;
            divz_d = 1'b1;
         end else begin
            res_d  = iALU_RESULT;
            divz_d = 1'b0;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         res_q  <= 8'h00;
         divz_q <= 1'b0;
      end else begin
         res_q  <= res_d;
         divz_q <= divz_d;
      end
   end

   // Decoded from the registered state so reset clears it at once.
   assign bus.oRES_VALID = (state_q == OUT);
   assign bus.oRESULT    = res_q;
   assign bus.oDIVZ      = divz_q;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: directed commands push expected results,
// a negedge monitor pops and compares each accepted result.
module tb_alu_issue;

   logic       iCLK = 1'b0;
   logic       iRSTn;
   logic [3:0] oA, oB, oINST;
   logic [7:0] alu_res;
   logic [2:0] oCOUNT;

   alu_issue_if bus ();

   alu_issue #(.DEPTH(4)) dut (
      .iCLK        (iCLK),
      .iRSTn       (iRSTn),
      .bus         (bus),
      .oA          (oA),
      .oB          (oB),
      .oINST       (oINST),
      .iALU_RESULT (alu_res),
      .oCOUNT      (oCOUNT)
   );

   always #5 iCLK = ~iCLK;

   // stand-in combinational ALU (DIV/0 returns FF so the override is visible)
   always_comb begin
      alu_res = 8'h00;
      case (oINST)
         4'h0: alu_res = {4'h0, oA} + {4'h0, oB};
         4'h1: alu_res = {4'h0, oA} - {4'h0, oB};
         4'h2: alu_res = {4'h0, oA} * {4'h0, oB};
         4'h3: alu_res = (oB == 4'h0) ? 8'hFF : {4'h0, oA / oB};
         4'h4: alu_res = (oB == 4'h0) ? 8'hEE : {4'h0, oA % oB};
         4'hF: alu_res = {4'h0, oA} << oB;
         default: alu_res = 8'h00;
      endcase
   end

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         prev_hs = 0;
   bit         spacing_en = 0;
   bit         have_prev = 0;
   logic [8:0] exp_q [$];
   logic [8:0] mon_e;

   always @(posedge iCLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // monitor: a handshake seen here completes at the next rising edge
   always @(negedge iCLK) begin
      if (iRSTn && bus.oRES_VALID && bus.iRES_READY) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_result: got %0h divz %0b, want none",
                     bus.oRESULT, bus.oDIVZ);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result", int'(bus.oRESULT), int'(mon_e[8:1]));
            chk("divz", int'(bus.oDIVZ), int'(mon_e[0]));
         end
         if (spacing_en) begin
            if (have_prev) chk("spacing", cyc - prev_hs, 2);
            prev_hs   = cyc;
            have_prev = 1;
         end
      end
   end

   task automatic step();
      @(posedge iCLK);
      #1;
   endtask

   task automatic cmd(input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] op, input logic [7:0] r,
                      input logic dz, input bit track, output bit acc);
      bus.iCMD_VALID = 1'b1;
      bus.iCMD_A     = a;
      bus.iCMD_B     = b;
      bus.iCMD_INST  = op;
      @(negedge iCLK);
      acc = bus.oCMD_READY;
      if (acc && track) exp_q.push_back({r, dz});
      step();
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] op, input logic [7:0] r,
                       input logic dz);
      bit acc;
      acc = 0;
      for (int i = 0; i < 50 && !acc; i++) cmd(a, b, op, r, dz, 1, acc);
      bus.iCMD_VALID = 1'b0;
      chk("send_accepted", int'(acc), 1);
   endtask

   task automatic drain(input int lim);
      int i;
      i = 0;
      while (exp_q.size() != 0 && i < lim) begin
         step();
         i++;
      end
      step();
      chk("drain_left", exp_q.size(), 0);
   endtask

   logic [3:0] ta [6] = '{4'h1, 4'h2, 4'h4, 4'hF, 4'h6, 4'h1};
   logic [3:0] tb [6] = '{4'h1, 4'h3, 4'h4, 4'h1, 4'h7, 4'h2};
   logic [7:0] tr [6] = '{8'h02, 8'h05, 8'h08, 8'h10, 8'h0D, 8'h03};

   initial begin
      bit acc;
      int nacc;
      iRSTn          = 1'b0;
      bus.iCMD_VALID = 1'b0;
      bus.iCMD_A     = '0;
      bus.iCMD_B     = '0;
      bus.iCMD_INST  = '0;
      bus.iRES_READY = 1'b0;

      // reset with random inputs
      repeat (3) begin
         step();
         bus.iCMD_VALID = 1'($urandom);
         bus.iCMD_A     = 4'($urandom);
         bus.iCMD_B     = 4'($urandom);
         bus.iCMD_INST  = 4'($urandom);
         bus.iRES_READY = 1'($urandom);
         @(negedge iCLK);
         chk("rst_valid", int'(bus.oRES_VALID), 0);
         chk("rst_result", int'(bus.oRESULT), 0);
         chk("rst_divz", int'(bus.oDIVZ), 0);
         chk("rst_ops", int'({oA, oB, oINST}), 0);
         chk("rst_count", int'(oCOUNT), 0);
      end
      step();
      bus.iCMD_VALID = 1'b0;
      bus.iRES_READY = 1'b0;
      iRSTn          = 1'b1;
      @(negedge iCLK);
      chk("rel_ready", int'(bus.oCMD_READY), 1);
      chk("rel_count", int'(oCOUNT), 0);

      // single ADD latency
      step();
      cmd(4'h7, 4'h9, 4'h0, 8'h10, 1'b0, 1, acc);
      bus.iCMD_VALID = 1'b0;
      chk("add_acc", int'(acc), 1);
      chk("add_n0_valid", int'(bus.oRES_VALID), 0);
      step();
      chk("add_n1_valid", int'(bus.oRES_VALID), 0);
      chk("add_n1_ops", int'({oA, oB, oINST}), 'h790);
      chk("add_n1_count", int'(oCOUNT), 0);
      step();
      chk("add_n2_valid", int'(bus.oRES_VALID), 1);
      chk("add_n2_result", int'(bus.oRESULT), 'h10);
      bus.iRES_READY = 1'b1;
      step();
      chk("add_idle_valid", int'(bus.oRES_VALID), 0);
      step();
      chk("add_idle_hold", int'(bus.oRES_VALID), 0);

      // DIV by zero then MOD
      send(4'h9, 4'h0, 4'h3, 8'h00, 1'b1);
      send(4'h9, 4'h4, 4'h4, 8'h01, 1'b0);
      drain(40);

      // backpressure: six back-to-back, five fit
      bus.iRES_READY = 1'b0;
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         cmd(ta[i], tb[i], 4'h0, tr[i], 1'b0, 1, acc);
         nacc += int'(acc);
      end
      bus.iCMD_VALID = 1'b0;
      chk("bp_accepted", nacc, 5);
      chk("bp_count", int'(oCOUNT), 4);
      chk("bp_ready", int'(bus.oCMD_READY), 0);
      repeat (3) step();
      chk("bp_valid", int'(bus.oRES_VALID), 1);
      chk("bp_stable", int'(bus.oRESULT), 'h02);
      have_prev      = 0;
      spacing_en     = 1;
      bus.iRES_READY = 1'b1;
      drain(60);
      spacing_en = 0;

      // ordering with toggling consumer
      bus.iRES_READY = 1'b0;
      cmd(4'hF, 4'hF, 4'h2, 8'hE1, 1'b0, 1, acc);
      cmd(4'h1, 4'h3, 4'hF, 8'h08, 1'b0, 1, acc);
      cmd(4'h3, 4'h5, 4'h1, 8'hFE, 1'b0, 1, acc);
      bus.iCMD_VALID = 1'b0;
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
         bus.iRES_READY = ~bus.iRES_READY;
         step();
      end
      bus.iRES_READY = 1'b1;
      drain(10);

      // mid-operation reset
      bus.iRES_READY = 1'b0;
      for (int i = 0; i < 4; i++) cmd(ta[i], tb[i], 4'h0, tr[i], 1'b0, 0, acc);
      bus.iCMD_VALID = 1'b0;
      chk("mr_valid_pre", int'(bus.oRES_VALID), 1);
      chk("mr_count_pre", int'(oCOUNT), 3);
      #2;
      iRSTn = 1'b0;
      #1;
      chk("mr_valid_async", int'(bus.oRES_VALID), 0);
      chk("mr_count_async", int'(oCOUNT), 0);
      step();
      step();
      iRSTn          = 1'b1;
      bus.iRES_READY = 1'b1;
      repeat (10) step();
      chk("mr_valid_after", int'(bus.oRES_VALID), 0);
      chk("mr_count_after", int'(oCOUNT), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule

// File: doc/alu_issue.md
# alu_issue

Sequencing stage wrapped around the combinational 4-bit ALU. Commands (A, B, opcode) arrive on a valid/ready port and are buffered in a DEPTH-entry FIFO. They are issued one at a time on registered operand lines to the ALU. The ALU's 8-bit result is captured one cycle later and presented on a valid/ready result port, with divide-by-zero flagging for DIV/MOD. The top level wires oA/oB/oINST to the ALU inputs and the ALU result back to iALU_RESULT.

## Interface
- DEPTH, 4, command FIFO entries; power of two, ≥ 2
- iCLK  in  1  clock, rising edge
- iRSTn  in  1  reset, asynchronous, active-low
- iCMD_VALID  in  1  command present
- oCMD_READY  out  1  FIFO can accept; = (oCOUNT != DEPTH)
- iCMD_A  in  4  operand A
- iCMD_B  in  4  operand B
- iCMD_INST  in  4  opcode; ADD=0, SUB=1, MUL=2, DIV=3, MOD=4, … LSHFT=F
- oA  out  4  registered operand A to ALU
- oB  out  4  registered operand B to ALU
- oINST  out  4  registered opcode to ALU
- iALU_RESULT  in  8  ALU combinational result
- oRES_VALID  out  1  result present
- iRES_READY  in  1  consumer accepts result
- oRESULT  out  8  registered result
- oDIVZ  out  1  result came from DIV/MOD with B=0
- oCOUNT  out  log2(DEPTH)+1  FIFO occupancy

## Operation
- Push: iCMD_VALID & oCMD_READY at a rising edge writes {A,B,INST} at the write pointer.
  - When full, oCMD_READY is low even if a pop occurs in the same cycle; no full-bypass.
- Pop: occurs only under the FSM rules below; reads the head entry into oA/oB/oINST.
- Pointers wrap modulo DEPTH. oCOUNT changes by +1, −1 or 0 on simultaneous push/pop.
- No empty-bypass: an entry pushed at edge N can pop no earlier than edge N+1.
- FSM, 2-bit state: IDLE=0, EXEC=1, OUT=2; code 3 → IDLE.
  - IDLE: if oCOUNT≠0, pop into oA/oB/oINST and go to EXEC; else stay.
  - EXEC: always lasts exactly one cycle. Capture iALU_RESULT into oRESULT; oDIVZ=0; go to OUT.
    - If oINST∈{3,4} and oB==0: oRESULT=8'h00, oDIVZ=1.
  - OUT: oRES_VALID=1.
    - oRESULT/oDIVZ are held stable until iRES_READY=1 at an edge.
    - On that edge: if oCOUNT≠0, pop next command into oA/oB/oINST and go to EXEC; else go to IDLE.
- oA/oB/oINST hold their last issued value in IDLE and OUT. oRES_VALID=1 only in OUT.
- Results leave in command-acceptance order.
- Width rules: the ALU computes in its 8-bit result context; this block applies no extension or truncation beyond capturing all 8 bits.

## Timing
- Reset (iRSTn low, asynchronous):
  - state=IDLE, FIFO pointers and oCOUNT=0;
  - oA=oB=oINST=0, oRESULT=8'h00, oDIVZ=0, oRES_VALID=0;
  - oCMD_READY=1 (FIFO empty).
- Reset asserted mid-operation flushes the FIFO and discards any in-flight or presented result immediately; oRES_VALID falls without waiting for a clock.
- Latency, empty FIFO, state IDLE:
  - command accepted at edge N → popped at N+1 → captured at N+2;
  - oRES_VALID high after edge N+2.
- Throughput with iRES_READY held high and FIFO non-empty: one result per 2 cycles (OUT→EXEC→OUT).
- iRES_READY is sampled only in OUT. oRES_VALID does not depend combinationally on iRES_READY.
- iALU_RESULT is sampled only at the EXEC edge. The ALU path has one full cycle from the oA/oB/oINST registers to that edge.

## Test plan
- Reset: hold iRSTn low for 3 cycles with random inputs → all outputs at reset values and oCOUNT=0; oCMD_READY=1 after release.
- Single ADD, A=4'h7, B=4'h9, accepted at edge N → oRES_VALID rises after N+2 with oRESULT=8'h10, oDIVZ=0. With iRES_READY=1, returns to IDLE.
- DIV A=9,B=0 then MOD A=9,B=4 → first result 8'h00 with oDIVZ=1; second 8'h01 with oDIVZ=0.
- Backpressure, DEPTH=4, iRES_READY=0, 6 back-to-back commands:
  - exactly 5 accepted (one issued, 4 queued); oCMD_READY low, oCOUNT=4, oRESULT stable;
  - then iRES_READY=1 → all 5 results in order, 2 cycles apart.
- Ordering: MUL F×F, LSHFT 1<<3, SUB 3−5, consumer ready toggling every cycle → 8'hE1, 8'h08, 8'hFE in that order, none lost or duplicated.
- Mid-operation reset: pulse iRSTn low with oRES_VALID=1 and oCOUNT=3 → oRES_VALID drops asynchronously, oCOUNT=0, and no result appears after release.
